regfile_param: RTL

// - Parametrised successor to the fixed 16x16, 2-read register file: configurable width, depth and read-port count.
// - Write-to-read bypass; optional hardwired-zero R0.
// - Sequenced bulk-clear engine (IDLE/CLEAR FSM) used by the core for context flush and soft restart.
// - Sits in the decode stage and feeds the ALU operand muxes.

---
 rtl/regfile_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with write-to-read bypass, optional
// hardwired-zero R0 and a sequenced bulk-clear engine.
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     clr_req_i,
  output logic                     busy_o,
  output logic                     clr_done_o,
  output logic                     wr_err_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wr_err_q, wr_err_d;
  logic                clr_done_s;
  logic                busy_s;
  logic                wr_accept_s;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign busy_s      = (state_q == S_CLEAR);
  assign wr_accept_s = wr_en_i & ~busy_s & ~((ZERO_R0 != 0) && (wr_addr_i == '0));

  // Clear sequencer: walks clr_cnt across every index once, then returns to IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_s = 1'b0;
    wr_err_d   = wr_en_i & busy_s;
    case (state_q)
      S_IDLE: begin
        if (clr_req_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          clr_done_s = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Storage array: the clear engine has priority, writes are refused while it runs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (busy_s) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_accept_s) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    assign addr_s = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign rd_data_o[k*DATA_W +: DATA_W] =
      ((ZERO_R0 != 0) && (addr_s == '0))    ? '0        :
      (wr_accept_s && (wr_addr_i == addr_s)) ? wr_data_i :
                                               mem_q[addr_s];
  end

  assign busy_o     = busy_s;
  assign clr_done_o = clr_done_s;
  assign wr_err_o   = wr_err_q;

endmodule
